mips_debug_loader: RTL
======================

// Module: mips_debug_loader
// PURPOSE
//  Upstream control stage of TOP_MIPS. Consumes a UART byte stream and drives the core's
//  program-load/run interface: i_instruccion, i_address, i_loading, i_start, i_step.
//  Assembles 32-bit instruction words from bytes, writes them to instruction memory,
//  then runs the core in continuous or single-step mode until o_finish.
// PARAMETERS
//  DATA_WIDTH  32  instruction / result word width (4 bytes)
//  MEM_DEPTH   64  instruction memory depth in words; load stops at the last word
// PORTS
//  i_clock        in   1   system clock
//  i_reset        in   1   synchronous active-high reset
//  i_rx_data      in   8   received UART byte
//  i_rx_done      in   1   1-cycle strobe; i_rx_data is valid
//  i_finish       in   1   core o_finish (HALT retired)
//  i_result_wb    in   32  core o_result_wb
//  i_tx_done      in   1   UART TX byte-complete strobe
//  o_instruccion  out  32  word to core i_instruccion
//  o_address      out  32  word index to core i_address
//  o_loading      out  1   to core i_loading
//  o_cpu_reset    out  1   1-cycle core reset pulse after load
//  o_start        out  1   to core i_start
//  o_step         out  1   to core i_step
//  o_tx_data      out  8   byte to UART TX
//  o_tx_start     out  1   1-cycle TX request
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, byte count 0, word index 0. Reset mid-operation aborts
//    immediately; a partially assembled word is discarded.
//  - Commands (IDLE only, unknown bytes ignored): 0x4C 'L' -> LOAD, 0x43 'C' -> RUN,
//    0x53 'S' -> STEP.
//  - LOAD: o_loading=1. Bytes arrive MSB first; 2-bit count wraps 3->0. On the cycle after
//    the 4th i_rx_done, o_instruccion and o_address update together (index 0,1,2,...).
//    Both hold stable between writes. Word index is incremented after each write.
//  - Load exit: after writing a word with [31:26]==6'h3F (HALT), or writing index MEM_DEPTH-1
//    -> LOAD_DONE. LOAD_DONE: o_loading=0, o_cpu_reset=1 for exactly 1 cycle, then IDLE.
//  - RUN: o_start=1 and o_step=1 held. On i_finish: both drop the next cycle -> IDLE.
//  - STEP: o_start=1. Byte 0x4E 'N' -> o_step=1 for exactly 1 cycle (cycle after rx_done).
//    Byte 0x45 'E' -> o_start=0 -> IDLE. Other bytes are ignored.
//  - STEP: i_finish has priority over a same-cycle 'N': no step pulse, o_start=0 -> IDLE.
//  - Latency: command byte to state change is 1 cycle. Nothing is queued; bytes arriving
//    in states that do not consume them are dropped.
// CONFIGURATION
//  RESULT_TX_EN defined: after each step pulse, and on i_finish in RUN, state TX sends
//    i_result_wb (sampled the cycle after the trigger) as 4 bytes MSB first.
//    Per byte: o_tx_start is a 1-cycle pulse with o_tx_data valid; wait for i_tx_done.
//    The block returns to the originating state (STEP) or to IDLE after byte 4.
//    Rx bytes arriving during TX are dropped.
//  RESULT_TX_EN undefined: no TX state; o_tx_start and o_tx_data are tied to 0.
// TESTING
//  1 'L',00,22,18,21,FC,00,00,00 -> write addr0=0x00221821, addr1=0xFC000000;
//    o_cpu_reset 1-cycle pulse; o_loading back to 0.
//  2 'L' then 3 bytes, then i_reset -> all outputs 0. 'L' plus 4 bytes then writes addr0
//    (partial word discarded).
//  3 'C' with i_finish asserted 20 cycles later -> o_start/o_step high for 20 cycles,
//    low the next cycle; state IDLE.
//  4 'S','N','N','E' -> exactly two 1-cycle o_step pulses, o_start high from 'S' until
//    the cycle after 'E'.
//  5 'S','N' with i_finish on the same cycle as the 'N' rx_done -> no o_step; o_start=0.
//  6 [RESULT_TX_EN] 'S','N' with i_result_wb=0x0000000C -> TX bytes 00,00,00,0C,
//    each gated by i_tx_done.

Source files
------------

// File: rtl/mips_debug_loader.sv
// UART-driven program loader and run/step controller for the MIPS core.
// Optional result readback over UART TX is enabled by defining RESULT_TX_EN.
module mips_debug_loader #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MEM_DEPTH  = 64
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic [7:0]            i_rx_data,
    input  logic                  i_rx_done,
    input  logic                  i_finish,
    input  logic [DATA_WIDTH-1:0] i_result_wb,
    input  logic                  i_tx_done,
    output logic [DATA_WIDTH-1:0] o_instruccion,
    output logic [DATA_WIDTH-1:0] o_address,
    output logic                  o_loading,
    output logic                  o_cpu_reset,
    output logic                  o_start,
    output logic                  o_step,
    output logic [7:0]            o_tx_data,
    output logic                  o_tx_start
);

    localparam int unsigned BYTES = DATA_WIDTH / 8;
    localparam int unsigned CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int unsigned ASM_W = DATA_WIDTH - 8;

    localparam logic [7:0] CMD_LOAD = 8'h4C;
    localparam logic [7:0] CMD_RUN  = 8'h43;
    localparam logic [7:0] CMD_STEP = 8'h53;
    localparam logic [7:0] CMD_NEXT = 8'h4E;
    localparam logic [7:0] CMD_END  = 8'h45;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LOAD      = 3'd1;
    localparam logic [2:0] S_LOAD_DONE = 3'd2;
    localparam logic [2:0] S_RUN       = 3'd3;
    localparam logic [2:0] S_STEP      = 3'd4;
`ifdef RESULT_TX_EN
    localparam logic [2:0] S_TX        = 3'd5;
`endif

    logic [2:0]            state_q,     state_nxt;
    logic [CNT_W-1:0]      cnt_q,       cnt_nxt;
    logic [IDX_W-1:0]      idx_q,       idx_nxt;
    logic [ASM_W-1:0]      asm_q,       asm_nxt;
    logic [DATA_WIDTH-1:0] instr_q,     instr_nxt;
    logic [DATA_WIDTH-1:0] addr_q,      addr_nxt;
    logic                  loading_q,   loading_nxt;
    logic                  cpu_reset_q, cpu_reset_nxt;
    logic                  start_q,     start_nxt;
    logic                  step_q,      step_nxt;
    logic [DATA_WIDTH-1:0] word_c;

    assign word_c = {asm_q, i_rx_data};

`ifdef RESULT_TX_EN
    logic [DATA_WIDTH-1:0] tx_word_q,  tx_word_nxt;
    logic [CNT_W-1:0]      tx_idx_q,   tx_idx_nxt;
    logic                  tx_wait_q,  tx_wait_nxt;
    logic [2:0]            tx_ret_q,   tx_ret_nxt;
    logic [7:0]            tx_data_q,  tx_data_nxt;
    logic                  tx_start_q, tx_start_nxt;
`endif

    // State and output registers
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            asm_q       <= '0;
            instr_q     <= '0;
            addr_q      <= '0;
            loading_q   <= 1'b0;
            cpu_reset_q <= 1'b0;
            start_q     <= 1'b0;
            step_q      <= 1'b0;
`ifdef RESULT_TX_EN
            tx_word_q   <= '0;
            tx_idx_q    <= '0;
            tx_wait_q   <= 1'b0;
            tx_ret_q    <= S_IDLE;
            tx_data_q   <= '0;
            tx_start_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_nxt;
            cnt_q       <= cnt_nxt;
            idx_q       <= idx_nxt;
            asm_q       <= asm_nxt;
            instr_q     <= instr_nxt;
            addr_q      <= addr_nxt;
            loading_q   <= loading_nxt;
            cpu_reset_q <= cpu_reset_nxt;
            start_q     <= start_nxt;
            step_q      <= step_nxt;
`ifdef RESULT_TX_EN
            tx_word_q   <= tx_word_nxt;
            tx_idx_q    <= tx_idx_nxt;
            tx_wait_q   <= tx_wait_nxt;
            tx_ret_q    <= tx_ret_nxt;
            tx_data_q   <= tx_data_nxt;
            tx_start_q  <= tx_start_nxt;
`endif
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt     = state_q;
        cnt_nxt       = cnt_q;
        idx_nxt       = idx_q;
        asm_nxt       = asm_q;
        instr_nxt     = instr_q;
        addr_nxt      = addr_q;
        loading_nxt   = loading_q;
        cpu_reset_nxt = 1'b0;
        start_nxt     = start_q;
        step_nxt      = 1'b0;
`ifdef RESULT_TX_EN
        tx_word_nxt   = tx_word_q;
        tx_idx_nxt    = tx_idx_q;
        tx_wait_nxt   = tx_wait_q;
        tx_ret_nxt    = tx_ret_q;
        tx_data_nxt   = tx_data_q;
        tx_start_nxt  = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (i_rx_done) begin
                    case (i_rx_data)
                        CMD_LOAD: begin
                            state_nxt   = S_LOAD;
                            loading_nxt = 1'b1;
                            cnt_nxt     = '0;
                            idx_nxt     = '0;
                        end
                        CMD_RUN: begin
                            state_nxt = S_RUN;
                            start_nxt = 1'b1;
                            step_nxt  = 1'b1;
                        end
                        CMD_STEP: begin
                            state_nxt = S_STEP;
                            start_nxt = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            S_LOAD: begin
                if (i_rx_done) begin
                    asm_nxt = word_c[ASM_W-1:0];
                    cnt_nxt = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(BYTES - 1)) begin
                        instr_nxt = word_c;
                        addr_nxt  = DATA_WIDTH'(idx_q);
                        idx_nxt   = idx_q + IDX_W'(1);
                        // HALT opcode or last memory word ends the load
                        if (word_c[DATA_WIDTH-1 -: 6] == OP_HALT ||
                            idx_q == IDX_W'(MEM_DEPTH - 1)) begin
                            state_nxt     = S_LOAD_DONE;
                            loading_nxt   = 1'b0;
                            cpu_reset_nxt = 1'b1;
                        end
                    end
                end
            end
            S_LOAD_DONE: begin
                state_nxt = S_IDLE;
            end
            S_RUN: begin
                if (i_finish) begin
                    start_nxt = 1'b0;
                    step_nxt  = 1'b0;
`ifdef RESULT_TX_EN
                    state_nxt   = S_TX;
                    tx_ret_nxt  = S_IDLE;
                    tx_idx_nxt  = '0;
                    tx_wait_nxt = 1'b0;
`else
                    state_nxt = S_IDLE;
`endif
                end else begin
                    step_nxt = 1'b1;
                end
            end
            S_STEP: begin
                // Core completion wins over a same-cycle step request
                if (i_finish) begin
                    start_nxt = 1'b0;
                    state_nxt = S_IDLE;
                end else if (i_rx_done) begin
                    if (i_rx_data == CMD_NEXT) begin
                        step_nxt = 1'b1;
`ifdef RESULT_TX_EN
                        state_nxt   = S_TX;
                        tx_ret_nxt  = S_STEP;
                        tx_idx_nxt  = '0;
                        tx_wait_nxt = 1'b0;
`endif
                    end else if (i_rx_data == CMD_END) begin
                        start_nxt = 1'b0;
                        state_nxt = S_IDLE;
                    end
                end
            end
`ifdef RESULT_TX_EN
            S_TX: begin
                // First TX cycle samples the result; later bytes wait on tx_done
                if (!tx_wait_q) begin
                    tx_data_nxt  = i_result_wb[DATA_WIDTH-1 -: 8];
                    tx_word_nxt  = {i_result_wb[DATA_WIDTH-9:0], 8'h00};
                    tx_start_nxt = 1'b1;
                    tx_wait_nxt  = 1'b1;
                end else if (i_tx_done) begin
                    if (tx_idx_q == CNT_W'(BYTES - 1)) begin
                        state_nxt   = tx_ret_q;
                        tx_wait_nxt = 1'b0;
                    end else begin
                        tx_idx_nxt   = tx_idx_q + CNT_W'(1);
                        tx_data_nxt  = tx_word_q[DATA_WIDTH-1 -: 8];
                        tx_word_nxt  = {tx_word_q[DATA_WIDTH-9:0], 8'h00};
                        tx_start_nxt = 1'b1;
                    end
                end
            end
`endif
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign o_instruccion = instr_q;
    assign o_address     = addr_q;
    assign o_loading     = loading_q;
    assign o_cpu_reset   = cpu_reset_q;
    assign o_start       = start_q;
    assign o_step        = step_q;

`ifdef RESULT_TX_EN
    assign o_tx_data  = tx_data_q;
    assign o_tx_start = tx_start_q;
`else
    logic unused_tx_inputs;
    assign unused_tx_inputs = ^{i_result_wb, i_tx_done};
    assign o_tx_data  = '0;
    assign o_tx_start = 1'b0;
`endif

endmodule
